// File: rtl/rtu_rob_ptr_ctrl_if.sv
// ----------------------------------------------------------------------------
// rtu_rob_ptr_ctrl_if
//   Bundles the allocation, head-select, retire and occupancy signals between
//   the reorder-buffer pointer controller and its surroundings.
//   master : dispatch/entry side. Drives alloc_req, entry_retire_vld and
//            rtu_global_flush; observes everything else.
//   slave  : the pointer controller.
//   Signals:
//     alloc_req        dispatch wants one entry this cycle
//     alloc_gnt        request accepted this cycle
//     alloc_iid        index handed to the accepted request (tail)
//     create_vld_oh    one-hot create strobe to the entry array
//     head_vld_oh      one-hot head select to the entry array (0 when empty)
//     entry_retire_vld per-entry retire indication
//     rtu_global_flush clear all entries and pointers
//     retire_pulse     registered: an entry retired last cycle
//     retire_iid       registered: index of that entry
//     rob_full/rob_empty/rob_cnt  occupancy
//     rob_err          sticky protocol error
// ----------------------------------------------------------------------------
interface rtu_rob_ptr_ctrl_if #(
    parameter int ENTRIES = 8,
    parameter int IID_W   = 3
);
    logic               alloc_req;
    logic               alloc_gnt;
    logic [IID_W-1:0]   alloc_iid;
    logic [ENTRIES-1:0] create_vld_oh;
    logic [ENTRIES-1:0] head_vld_oh;
    logic [ENTRIES-1:0] entry_retire_vld;
    logic               rtu_global_flush;
    logic               retire_pulse;
    logic [IID_W-1:0]   retire_iid;
    logic               rob_full;
    logic               rob_empty;
    logic [IID_W:0]     rob_cnt;
    logic               rob_err;

    modport master (
        output alloc_req, entry_retire_vld, rtu_global_flush,
        input  alloc_gnt, alloc_iid, create_vld_oh, head_vld_oh,
               retire_pulse, retire_iid, rob_full, rob_empty, rob_cnt, rob_err
    );

    modport slave (
        input  alloc_req, entry_retire_vld, rtu_global_flush,
        output alloc_gnt, alloc_iid, create_vld_oh, head_vld_oh,
               retire_pulse, retire_iid, rob_full, rob_empty, rob_cnt, rob_err
    );
endinterface

// File: rtl/rtu_rob_ptr_ctrl.sv
// ----------------------------------------------------------------------------
// rtu_rob_ptr_ctrl
//   Head/tail pointer controller for the reorder buffer. Grants one entry per
//   cycle at the tail, selects the head entry, retires the head in order,
//   reports occupancy and flags out-of-order retire indications.
//   Ports:
//     clk     rising-edge clock
//     rst_clk synchronous active-high reset (priority over everything)
//     rob     slave side of rtu_rob_ptr_ctrl_if (see interface header)
// ----------------------------------------------------------------------------
module rtu_rob_ptr_ctrl #(
    parameter int ENTRIES = 8,
    parameter int IID_W   = 3
) (
    input  logic               clk,
    input  logic               rst_clk,
    rtu_rob_ptr_ctrl_if.slave  rob
);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [IID_W:0]     head_ptr;
    logic [IID_W:0]     tail_ptr;
    logic [IID_W-1:0]   head_idx;
    logic [IID_W-1:0]   tail_idx;
    logic               empty;
    logic               full;
    logic               gnt;
    logic               do_retire;
    logic               err_hit;
    logic [ENTRIES-1:0] create_oh;
    logic [ENTRIES-1:0] head_oh;
    logic               retire_pulse_q;
    logic [IID_W-1:0]   retire_iid_q;
    logic               err_q;

    assign head_idx = head_ptr[IID_W-1:0];
    assign tail_idx = tail_ptr[IID_W-1:0];
    assign empty    = (head_ptr == tail_ptr);
    assign full     = (head_idx == tail_idx) && (head_ptr[IID_W] != tail_ptr[IID_W]);

    // Fullness comes from registered pointers only: a retire in the same
    // cycle does not make room until the next cycle.
    assign gnt = rob.alloc_req & ~full & ~rob.rtu_global_flush & ~rst_clk;

    always_comb begin
        create_oh = '0;
        head_oh   = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            create_oh[i] = gnt && (tail_idx == IID_W'(i));
            head_oh[i]   = !empty && (head_idx == IID_W'(i));
        end
    end

    assign do_retire = ~empty & rob.entry_retire_vld[head_idx] & ~rob.rtu_global_flush;

    // head_oh is zero when empty, so masking with it covers both the
    // non-head case and the retire-while-empty case.
    assign err_hit = (|(rob.entry_retire_vld & ~head_oh)) & ~rob.rtu_global_flush;

    always_ff @(posedge clk) begin
        if (rst_clk) begin
            head_ptr       <= '0;
            tail_ptr       <= '0;
            retire_pulse_q <= 1'b0;
            retire_iid_q   <= '0;
            err_q          <= 1'b0;
        end else if (rob.rtu_global_flush) begin
            head_ptr       <= '0;
            tail_ptr       <= '0;
            retire_pulse_q <= 1'b0;
        end else begin
            if (gnt) begin
                tail_ptr <= tail_ptr + 1'b1;
            end
            if (do_retire) begin
                head_ptr     <= head_ptr + 1'b1;
                retire_iid_q <= head_idx;
            end
            retire_pulse_q <= do_retire;
            if (err_hit) begin
                err_q <= 1'b1;
            end
        end
    end

    assign rob.alloc_gnt     = gnt;
    assign rob.alloc_iid     = tail_idx;
    assign rob.create_vld_oh = create_oh;
    assign rob.head_vld_oh   = head_oh;
    assign rob.retire_pulse  = retire_pulse_q;
    assign rob.retire_iid    = retire_iid_q;
    assign rob.rob_full      = full;
    assign rob.rob_empty     = empty;
    assign rob.rob_cnt       = tail_ptr - head_ptr;
    assign rob.rob_err       = err_q;

endmodule
